// File: rtl/or_event_collector_if.sv
`default_nettype none
// ============================================================================
//  Module      : or_event_collector_if
//  Description : Request/mask/clear bundle between a requester and the
//                sticky OR event collector.
//  Revision    : 1.0  initial release
// ============================================================================
interface or_event_collector_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] mask;
    logic             clr_valid;
    logic [WIDTH-1:0] clr_mask;
    logic             clr_ready;
    logic             cnt_clr;
    logic [WIDTH-1:0] pending;
    logic             out;
    logic [7:0]       event_cnt;

    // Requester side: drives lines, mask and clear requests
    modport master (
        output in, mask, clr_valid, clr_mask, cnt_clr,
        input  clr_ready, pending, out, event_cnt
    );

    // Collector side
    modport slave (
        input  in, mask, clr_valid, clr_mask, cnt_clr,
        output clr_ready, pending, out, event_cnt
    );
endinterface
`default_nettype wire

// File: rtl/or_event_collector.sv
`default_nettype none
// ============================================================================
//  Module      : or_event_collector
//  Description : Edge-detects WIDTH request lines into sticky pending bits,
//                drives a stretched OR of the masked pending bits, supports
//                valid/ready clearing and a saturating edge-cycle counter.
//  Revision    : 1.0  initial release
// ============================================================================
module or_event_collector #(
    parameter int WIDTH   = 4,
    parameter int STRETCH = 3
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    or_event_collector_if.slave bus
);
    // Counter wide enough for STRETCH-1, at least one bit
    localparam int c_CW = (STRETCH > 1) ? $clog2(STRETCH) : 1;
    localparam logic [c_CW-1:0] c_LOAD = c_CW'(STRETCH - 1);
    localparam logic [7:0] c_CNT_MAX = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STRETCH = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    state_t            r_state;
    logic [c_CW-1:0]   r_cnt;
    logic              r_out;
    logic [WIDTH-1:0]  r_in_q;
    logic [WIDTH-1:0]  r_pending;
    logic [7:0]        r_event_cnt;

    logic [WIDTH-1:0]  w_edge;
    logic [WIDTH-1:0]  w_clr_bits;
    logic              w_clr_ready;
    logic              w_fire;
    logic              w_any;

    // Rising edges, handshake and combined OR
    always_comb begin
        w_edge      = bus.in & ~r_in_q;
        w_clr_ready = (r_state != ST_STRETCH) || (r_cnt == '0);
        w_fire      = bus.clr_valid & w_clr_ready;
        w_clr_bits  = w_fire ? bus.clr_mask : '0;
        w_any       = |(r_pending & bus.mask);
    end

    // Input history and sticky pending bits; a new edge beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_in_q    <= '0;
            r_pending <= '0;
        end else begin
            r_in_q    <= bus.in;
            r_pending <= (r_pending & ~w_clr_bits) | w_edge;
        end
    end

    // Saturating count of cycles with any edge; clearing wins over counting
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_event_cnt <= '0;
        end else if (bus.cnt_clr) begin
            r_event_cnt <= '0;
        end else if ((|w_edge) && (r_event_cnt != c_CNT_MAX)) begin
            r_event_cnt <= r_event_cnt + 8'd1;
        end
    end

    // Output stretcher: minimum-high window, then hold while any masked bit is pending
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_out   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state <= ST_STRETCH;
                        r_cnt   <= c_LOAD;
                        r_out   <= 1'b1;
                    end
                end
                ST_STRETCH: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (w_any) begin
                        r_state <= ST_HOLD;
                    end else begin
                        r_state <= ST_IDLE;
                        r_out   <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (!w_any) begin
                        r_state <= ST_IDLE;
                        r_out   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_out   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.clr_ready = w_clr_ready;
    assign bus.pending   = r_pending;
    assign bus.out       = r_out;
    assign bus.event_cnt = r_event_cnt;
endmodule
`default_nettype wire
